// File: rtl/puf_mapping_ctrl.sv
// Drives an external PUF core through NUM_EVALS arm/settle/sample passes per challenge and
// majority-votes the sampled responses, flagging bits whose samples disagreed.
module puf_mapping_ctrl #(
    parameter int IN_WIDTH      = 128,
    parameter int OUT_WIDTH     = 16,
    parameter int CFG_WIDTH     = 32,
    parameter int SETTLE_CYCLES = 16,
    parameter int NUM_EVALS     = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 trigger,
    input  logic [IN_WIDTH-1:0]  data_in,
    input  logic [CFG_WIDTH-1:0] cfg_in,
    output logic                 busy,
    output logic                 done,
    output logic [OUT_WIDTH-1:0] data_out,
    output logic [OUT_WIDTH-1:0] unstable,
    output logic [IN_WIDTH-1:0]  puf_challenge,
    output logic [CFG_WIDTH-1:0] puf_cfg,
    output logic                 puf_trigger,
    output logic                 puf_reset,
    input  logic [OUT_WIDTH-1:0] puf_response
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int EW = $clog2(NUM_EVALS + 1);
    localparam int CW = EW;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [EW-1:0] EVAL_LAST   = EW'(NUM_EVALS - 1);
    localparam logic [CW-1:0] VOTE_HALF   = CW'(NUM_EVALS / 2);
    localparam logic [CW-1:0] VOTE_FULL   = CW'(NUM_EVALS);

    typedef enum logic [2:0] {IDLE, ARM, EVAL, RECOVER, DONE} state_t;

    state_t          state, state_nxt;
    logic [SW-1:0]   settle_cnt;
    logic [EW-1:0]   eval_cnt;
    logic [CW-1:0]   ones_cnt [OUT_WIDTH];
    logic [CW-1:0]   cnt_nxt  [OUT_WIDTH];
    logic            accept;
    logic            sample;

    // An even-count tie resolves to 0 because the comparison is strict.
    function automatic logic vote_bit(input logic [CW-1:0] c);
        return c > VOTE_HALF;
    endfunction

    function automatic logic unstable_bit(input logic [CW-1:0] c);
        return (c != '0) && (c != VOTE_FULL);
    endfunction

    always_comb begin
        state_nxt   = state;
        busy        = 1'b1;
        done        = 1'b0;
        puf_trigger = 1'b0;
        puf_reset   = 1'b0;
        accept      = 1'b0;
        sample      = 1'b0;
        case (state)
            IDLE: begin
                busy      = 1'b0;
                puf_reset = 1'b1;
                if (trigger) begin
                    accept    = 1'b1;
                    state_nxt = ARM;
                end
            end
            ARM:     state_nxt = EVAL;
            EVAL: begin
                puf_trigger = 1'b1;
                if (settle_cnt == SETTLE_LAST) begin
                    sample    = 1'b1;
                    state_nxt = (eval_cnt == EVAL_LAST) ? DONE : RECOVER;
                end
            end
            RECOVER: begin
                puf_reset = 1'b1;
                state_nxt = ARM;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < OUT_WIDTH; i++) begin
            cnt_nxt[i] = ones_cnt[i] + CW'(puf_response[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            settle_cnt    <= '0;
            eval_cnt      <= '0;
            puf_challenge <= '0;
            puf_cfg       <= '0;
            data_out      <= '0;
            unstable      <= '0;
            for (int i = 0; i < OUT_WIDTH; i++) ones_cnt[i] <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                puf_challenge <= data_in;
                puf_cfg       <= cfg_in;
                eval_cnt      <= '0;
                for (int i = 0; i < OUT_WIDTH; i++) ones_cnt[i] <= '0;
            end
            if (state == ARM) begin
                settle_cnt <= '0;
            end else if (state == EVAL) begin
                settle_cnt <= settle_cnt + SW'(1);
            end
            // Results are loaded on the edge into DONE so they are valid alongside the done pulse.
            if (sample) begin
                eval_cnt <= eval_cnt + EW'(1);
                for (int i = 0; i < OUT_WIDTH; i++) begin
                    ones_cnt[i] <= cnt_nxt[i];
                    if (state_nxt == DONE) begin
                        data_out[i] <= vote_bit(cnt_nxt[i]);
                        unstable[i] <= unstable_bit(cnt_nxt[i]);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_puf_mapping_ctrl.sv
// Scoreboard bench: one DUT with NUM_EVALS=1 and one with NUM_EVALS=3, driven by a simple core model.
module tb_puf_mapping_ctrl;

    localparam int IW = 128;
    localparam int OW = 16;
    localparam int CF = 32;
    localparam int S  = 16;

    typedef struct {
        int              d;
        logic [OW-1:0]   data;
        logic [OW-1:0]   unst;
        int              cyc;
        logic [IW-1:0]   ch;
        logic [CF-1:0]   cf;
    } exp_t;

    logic          clk;
    logic          rst    [2];
    logic          trig   [2];
    logic          busy   [2];
    logic          done_o [2];
    logic          ptrig  [2];
    logic          preset [2];
    logic [OW-1:0] dout   [2];
    logic [OW-1:0] unst   [2];
    logic [OW-1:0] resp   [2];
    logic [IW-1:0] din    [2];
    logic [IW-1:0] pch    [2];
    logic [CF-1:0] cfg    [2];
    logic [CF-1:0] pcfg   [2];

    exp_t          sb[$];
    logic [OW-1:0] tbl [2][3];
    int            tlen [2];
    int            tpul [2];
    int            idx  [2];
    logic          prev [2];
    int            cyc = 0;
    int            tests = 0;
    int            fails = 0;

    puf_mapping_ctrl #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .CFG_WIDTH(CF),
                       .SETTLE_CYCLES(S), .NUM_EVALS(1)) dut1 (
        .clk(clk), .reset(rst[0]), .trigger(trig[0]), .data_in(din[0]), .cfg_in(cfg[0]),
        .busy(busy[0]), .done(done_o[0]), .data_out(dout[0]), .unstable(unst[0]),
        .puf_challenge(pch[0]), .puf_cfg(pcfg[0]), .puf_trigger(ptrig[0]),
        .puf_reset(preset[0]), .puf_response(resp[0]));

    puf_mapping_ctrl #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .CFG_WIDTH(CF),
                       .SETTLE_CYCLES(S), .NUM_EVALS(3)) dut3 (
        .clk(clk), .reset(rst[1]), .trigger(trig[1]), .data_in(din[1]), .cfg_in(cfg[1]),
        .busy(busy[1]), .done(done_o[1]), .data_out(dout[1]), .unstable(unst[1]),
        .puf_challenge(pch[1]), .puf_cfg(pcfg[1]), .puf_trigger(ptrig[1]),
        .puf_reset(preset[1]), .puf_response(resp[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ne(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string name, input logic [IW-1:0] got, input logic [IW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Core model, protocol checks and scoreboard consumer for one DUT.
    task automatic monitor(input int d);
        exp_t e;
        if (rst[d]) begin
            tlen[d] = 0; tpul[d] = 0; idx[d] = 0; prev[d] = 1'b0;
            return;
        end
        if (ptrig[d] && !prev[d]) begin
            tpul[d]++;
            resp[d] = tbl[d][(idx[d] < 3) ? idx[d] : 2];
            idx[d]++;
        end
        if (ptrig[d]) begin
            tlen[d]++;
        end else if (prev[d]) begin
            chk("trig_len", 128'(tlen[d]), 128'(S));
            if (!done_o[d]) chk("recover_reset", 128'(preset[d]), 128'(1));
            tlen[d] = 0;
        end
        if (done_o[d]) begin
            chk("pulses_per_run", 128'(tpul[d]), 128'(ne(d)));
            tpul[d] = 0; idx[d] = 0;
            chk("done_expected", 128'(sb.size() != 0), 128'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("done_dut", 128'(d), 128'(e.d));
                chk("data_out", 128'(dout[d]), 128'(e.data));
                chk("unstable", 128'(unst[d]), 128'(e.unst));
                chk("done_cycle", 128'(cyc), 128'(e.cyc));
                chk("challenge", pch[d], e.ch);
                chk("cfg", 128'(pcfg[d]), 128'(e.cf));
            end
        end
        prev[d] = ptrig[d];
    endtask

    always @(negedge clk) monitor(0);
    always @(negedge clk) monitor(1);

    task automatic push(input int d, input logic [OW-1:0] ed, input logic [OW-1:0] eu,
                        input int c, input logic [IW-1:0] ch, input logic [CF-1:0] cf);
        exp_t e;
        e.d = d; e.data = ed; e.unst = eu; e.cyc = c; e.ch = ch; e.cf = cf;
        sb.push_back(e);
    endtask

    task automatic start(input int d, input logic [IW-1:0] ch, input logic [CF-1:0] cf,
                         input logic [OW-1:0] r0, input logic [OW-1:0] r1, input logic [OW-1:0] r2,
                         input logic [OW-1:0] ed, input logic [OW-1:0] eu, output int t);
        int n = 0;
        @(negedge clk);
        while (busy[d] && n < 1000) begin
            @(negedge clk);
            n++;
        end
        tbl[d][0] = r0; tbl[d][1] = r1; tbl[d][2] = r2;
        din[d] = ch; cfg[d] = cf; trig[d] = 1'b1;
        t = cyc;
        push(d, ed, eu, t + ne(d) * (S + 2), ch, cf);
        @(negedge clk);
        trig[d] = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || busy[0] || busy[1]) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            tests++; fails++;
            $display("FAIL drain_timeout: %0d expectations still pending", sb.size());
        end
    endtask

    initial begin
        int t;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; trig[d] = 1'b0; din[d] = '0; cfg[d] = '0; resp[d] = '0;
            tlen[d] = 0; tpul[d] = 0; idx[d] = 0; prev[d] = 1'b0;
            for (int k = 0; k < 3; k++) tbl[d][k] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_done", 128'(done_o[d]), 128'(0));
            chk("rst_data", 128'(dout[d]), 128'(0));
            chk("rst_unst", 128'(unst[d]), 128'(0));
            chk("rst_busy", 128'(busy[d]), 128'(0));
            chk("rst_ptrig", 128'(ptrig[d]), 128'(0));
            chk("rst_preset", 128'(preset[d]), 128'(1));
            chk("rst_chal", pch[d], 128'(0));
            chk("rst_cfg", 128'(pcfg[d]), 128'(0));
        end
        rst[0] = 1'b0; rst[1] = 1'b0;

        // Single-evaluation DUT
        start(0, 128'h0123_4567_89AB_CDEF, 32'hDEAD_BEEF, 16'hA5C3, 16'h0, 16'h0, 16'hA5C3, 16'h0, t);
        drain();
        start(0, 128'h1, 32'h2, 16'hFFFF, 16'h0, 16'h0, 16'hFFFF, 16'h0, t);
        drain();
        start(0, 128'h3, 32'h4, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0, t);
        drain();

        // Three-evaluation voting
        start(1, 128'hCAFE, 32'h0A0B_0C0D, 16'h00FF, 16'h0F0F, 16'h00FF, 16'h00FF, 16'h0FF0, t);
        drain();
        start(1, 128'hBEEF, 32'h1, 16'hFFFF, 16'h0000, 16'hAAAA, 16'hAAAA, 16'hFFFF, t);
        drain();
        start(1, 128'h5555, 32'h2, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h0000, t);
        drain();

        // Triggers and data_in changes while busy are ignored
        start(1, 128'h1111_2222, 32'h33, 16'hF0F0, 16'hF0F0, 16'h0F0F, 16'hF0F0, 16'hFFFF, t);
        wait_cyc(t + 5);
        trig[1] = 1'b1; din[1] = 128'h9999; cfg[1] = 32'h77;
        @(negedge clk);
        trig[1] = 1'b0;
        chk("busy_chal_hold", pch[1], 128'h1111_2222);
        wait_cyc(t + 30);
        trig[1] = 1'b1; din[1] = 128'h8888;
        @(negedge clk);
        trig[1] = 1'b0;
        chk("busy_chal_hold2", pch[1], 128'h1111_2222);
        chk("busy_cfg_hold", 128'(pcfg[1]), 128'(32'h33));
        drain();

        // Trigger held high: back-to-back runs
        @(negedge clk);
        tbl[1][0] = 16'hFFFF; tbl[1][1] = 16'hFFFF; tbl[1][2] = 16'h0000;
        din[1] = 128'h4242; cfg[1] = 32'h99; trig[1] = 1'b1;
        t = cyc;
        for (int r = 0; r < 3; r++) push(1, 16'hFFFF, 16'hFFFF, t + 54 + r * 55, 128'h4242, 32'h99);
        wait_cyc(t + 164);
        trig[1] = 1'b0;
        drain();

        // Reset during EVAL of the second pass aborts the run
        start(1, 128'h7777, 32'h5, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0, t);
        wait_cyc(t + 24);
        chk("pre_abort_ptrig", 128'(ptrig[1]), 128'(1));
        rst[1] = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        chk("abort_preset", 128'(preset[1]), 128'(1));
        chk("abort_data", 128'(dout[1]), 128'(0));
        chk("abort_unst", 128'(unst[1]), 128'(0));
        chk("abort_busy", 128'(busy[1]), 128'(0));
        chk("abort_done", 128'(done_o[1]), 128'(0));
        chk("abort_chal", pch[1], 128'(0));
        rst[1] = 1'b0;
        repeat (60) @(negedge clk);
        start(1, 128'hABCD, 32'h6, 16'h1111, 16'h3333, 16'h7777, 16'h3333, 16'h6666, t);
        drain();

        chk("sb_empty", 128'(sb.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
